prio_encoder_scan: RTL and testbench

- Parametrised, registered successor to the 16-line cascaded priority encoder. Active-low request lines are synchronised and priority-encoded each cycle, highest index wins, with 74148-style GS/EO semantics.
- Adds a first-hit latch mode and a time-multiplexed, decimal seven-segment display of the winning index.
- Sits between the board switch/button inputs and the seven-segment display pins.

---
 rtl/prio_enc_pkg.sv | 29 ++
 rtl/prio_encoder_scan_if.sv | 29 ++
 rtl/seg_scan_mux.sv | 77 +++++++
 rtl/prio_encoder_scan.sv | 107 ++++++++++
 tb/tb_prio_encoder_scan.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/prio_enc_pkg.sv
// rtl/prio_enc_pkg.sv - shared types and seven-segment helpers for prio_encoder_scan
package prio_enc_pkg;

  typedef enum logic {
    TRACK = 1'b0,
    HELD  = 1'b1
  } state_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // Active-low gfedcba pattern for a decimal digit; anything else is dark.
  function automatic logic [6:0] seg7_hex(input logic [3:0] d);
    case (d)
      4'd0:    seg7_hex = 7'h40;
      4'd1:    seg7_hex = 7'h79;
      4'd2:    seg7_hex = 7'h24;
      4'd3:    seg7_hex = 7'h30;
      4'd4:    seg7_hex = 7'h19;
      4'd5:    seg7_hex = 7'h12;
      4'd6:    seg7_hex = 7'h02;
      4'd7:    seg7_hex = 7'h78;
      4'd8:    seg7_hex = 7'h00;
      4'd9:    seg7_hex = 7'h10;
      default: seg7_hex = 7'h7F;
    endcase
  endfunction

endpackage

// File: rtl/prio_encoder_scan_if.sv
// rtl/prio_encoder_scan_if.sv - request, encoder result and display pins of prio_encoder_scan
interface prio_encoder_scan_if #(
  parameter int N_IN   = 16,
  parameter int IDX_W  = $clog2(N_IN),
  parameter int DIGITS = 2
);

  logic [N_IN-1:0]   din_n;
  logic              ei_n;
  logic              latch_mode;
  logic              clear;
  logic [IDX_W-1:0]  idx;
  logic              gs_n;
  logic              eo_n;
  logic              held;
  logic [7:0]        seg;
  logic [DIGITS-1:0] an;

  modport master (
    output din_n, ei_n, latch_mode, clear,
    input  idx, gs_n, eo_n, held, seg, an
  );

  modport slave (
    input  din_n, ei_n, latch_mode, clear,
    output idx, gs_n, eo_n, held, seg, an
  );

endinterface

// File: rtl/seg_scan_mux.sv
// rtl/seg_scan_mux.sv - time-multiplexed decimal seven-segment driver for the encoded index
module seg_scan_mux
  import prio_enc_pkg::*;
#(
  parameter int IDX_W    = 4,
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IDX_W-1:0]  idx_i,
  input  logic              gs_n_i,
  input  logic              held_i,
  output logic [7:0]        seg_o,
  output logic [DIGITS-1:0] an_o
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int SEL_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [CNT_W-1:0]  scan_cnt_q;
  logic [SEL_W-1:0]  digit_sel_q;
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;
  logic [3:0]        digit_val;
  logic              lead_zero;
  int unsigned       place;
  int unsigned       value;
  int                sel;

  // Loop unrolls to one constant divide per digit position, then muxes by digit_sel.
  always_comb begin
    place     = 1;
    value     = 32'(idx_i);
    sel       = 32'(digit_sel_q);
    digit_val = '0;
    lead_zero = 1'b0;
    for (int k = 0; k < DIGITS; k++) begin
      if (sel == k) begin
        digit_val = 4'((value / place) % 10);
        lead_zero = (k != 0) && (value < place);
      end
      place = place * 10;
    end

    if (gs_n_i) begin
      seg_d = SEG_DASH;
    end else if (lead_zero) begin
      seg_d = SEG_BLANK;
    end else begin
      seg_d = {~(held_i && (digit_sel_q == '0)), seg7_hex(digit_val)};
    end
    an_d = ~(DIGITS'(1) << digit_sel_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_q  <= '0;
      digit_sel_q <= '0;
      seg_q       <= SEG_BLANK;
      an_q        <= '1;
    end else begin
      if (scan_cnt_q == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt_q  <= '0;
        digit_sel_q <= (digit_sel_q == SEL_W'(DIGITS - 1)) ? '0 : digit_sel_q + SEL_W'(1);
      end else begin
        scan_cnt_q <= scan_cnt_q + CNT_W'(1);
      end
      seg_q <= seg_d;
      an_q  <= an_d;
    end
  end

  assign seg_o = seg_q;
  assign an_o  = an_q;

endmodule

// File: rtl/prio_encoder_scan.sv
// rtl/prio_encoder_scan.sv - synchronised active-low priority encoder with first-hit latch and 7-seg scan
module prio_encoder_scan #(
  parameter int N_IN     = 16,
  parameter int IDX_W    = $clog2(N_IN),
  parameter int DIGITS   = 2,
  parameter int SCAN_DIV = 1000
) (
  input logic               clk,
  input logic               rst_n,
  prio_encoder_scan_if.slave bus
);

  import prio_enc_pkg::*;

  logic [N_IN-1:0]  din_s1_q, din_sync_q;
  logic             ei_s1_q, ei_sync_q;
  logic [IDX_W-1:0] enc_idx_d;
  logic             enc_any;
  logic             enc_gs_n_d, enc_eo_n_d;
  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic             gs_n_q, eo_n_q, held_q;

  // Inactive (all-ones) reset keeps a reset release from looking like a burst of requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      din_s1_q   <= '1;
      din_sync_q <= '1;
      ei_s1_q    <= 1'b1;
      ei_sync_q  <= 1'b1;
    end else begin
      din_s1_q   <= bus.din_n;
      din_sync_q <= din_s1_q;
      ei_s1_q    <= bus.ei_n;
      ei_sync_q  <= ei_s1_q;
    end
  end

  always_comb begin
    enc_idx_d = '0;
    enc_any   = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      if (!din_sync_q[i]) begin
        enc_idx_d = IDX_W'(i);
        enc_any   = 1'b1;
      end
    end
    if (ei_sync_q) begin
      enc_idx_d = '0;
    end
    enc_gs_n_d = ei_sync_q | ~enc_any;
    enc_eo_n_d = ei_sync_q | enc_any;
  end

  // Leaving HELD always lands in TRACK for one edge, so clear beats a simultaneous hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= TRACK;
      idx_q   <= '0;
      gs_n_q  <= 1'b1;
      eo_n_q  <= 1'b1;
      held_q  <= 1'b0;
    end else begin
      case (state_q)
        TRACK: begin
          idx_q  <= enc_idx_d;
          gs_n_q <= enc_gs_n_d;
          eo_n_q <= enc_eo_n_d;
          if (bus.latch_mode && !enc_gs_n_d) begin
            state_q <= HELD;
            held_q  <= 1'b1;
          end
        end
        HELD: begin
          if (bus.clear || !bus.latch_mode) begin
            state_q <= TRACK;
            held_q  <= 1'b0;
            idx_q   <= enc_idx_d;
            gs_n_q  <= enc_gs_n_d;
            eo_n_q  <= enc_eo_n_d;
          end
        end
        default: state_q <= TRACK;
      endcase
    end
  end

  assign bus.idx  = idx_q;
  assign bus.gs_n = gs_n_q;
  assign bus.eo_n = eo_n_q;
  assign bus.held = held_q;

  seg_scan_mux #(
    .IDX_W   (IDX_W),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) u_seg_scan_mux (
    .clk   (clk),
    .rst_n (rst_n),
    .idx_i (idx_q),
    .gs_n_i(gs_n_q),
    .held_i(held_q),
    .seg_o (bus.seg),
    .an_o  (bus.an)
  );

endmodule

// File: tb/tb_prio_encoder_scan.sv
// tb/tb_prio_encoder_scan.sv - scoreboard bench for prio_encoder_scan
module tb_prio_encoder_scan;

  localparam int N_IN     = 16;
  localparam int DIGITS   = 2;
  localparam int SCAN_DIV = 8;

  typedef struct packed {
    logic [31:0] due;
    logic [3:0]  idx;
    logic        gs_n;
    logic        eo_n;
    logic        held;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  bit   ok;

  prio_encoder_scan_if #(.N_IN(N_IN), .DIGITS(DIGITS)) bus ();

  prio_encoder_scan #(
    .N_IN    (N_IN),
    .DIGITS  (DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [3:0] i, input logic g, input logic eo, input logic h);
    exp_t x;
    x.due = 32'(cyc + 3);
    x.idx = i;
    x.gs_n = g;
    x.eo_n = eo;
    x.held = h;
    sb.push_back(x);
  endtask

  task automatic wait_an(input logic [1:0] target, output bit found);
    int n;
    n = 0;
    while (bus.an == target && n < 200) begin step(1); n++; end
    while (bus.an != target && n < 200) begin step(1); n++; end
    found = (bus.an == target);
  endtask

  task automatic test_reset;
    #2 rst_n = 1'b0;
    step(2);
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n, bus.held} !== {4'd0, 1'b1, 1'b1, 1'b0})
      $display("FAIL reset_enc: got idx=%0d gs_n=%b eo_n=%b held=%b, want 0 1 1 0", bus.idx, bus.gs_n, bus.eo_n, bus.held);
    checks++;
    if (bus.seg !== 8'hFF) $display("FAIL reset_seg: got %h want ff", bus.seg);
    checks++;
    if (bus.an !== 2'b11) $display("FAIL reset_an: got %b want 11", bus.an);
    if (bus.seg !== 8'hFF || bus.an !== 2'b11 || {bus.idx, bus.gs_n, bus.eo_n, bus.held} !== 7'b0000110) errors++;
    rst_n = 1'b1;
  endtask

  task automatic test_basic;
    bus.ei_n = 1'b0;
    bus.din_n = 16'hFFFE;
    push(4'd0, 1'b0, 1'b1, 1'b0);
    step(2);
    checks++;
    if (bus.gs_n !== 1'b1) begin
      errors++;
      $display("FAIL basic_latency: gs_n=%b after 2 edges, want 1", bus.gs_n);
    end
    step(1);
    e = sb.pop_front();
    checks++;
    if (32'(cyc) !== e.due || {bus.idx, bus.gs_n, bus.eo_n, bus.held} !== {e.idx, e.gs_n, e.eo_n, e.held}) begin
      errors++;
      $display("FAIL basic_enc: got idx=%0d gs_n=%b eo_n=%b held=%b, want %0d %b %b %b", bus.idx, bus.gs_n, bus.eo_n, bus.held, e.idx, e.gs_n, e.eo_n, e.held);
    end
    step(1);
    wait_an(2'b10, ok);
    checks++;
    if (!ok || bus.seg !== 8'hC0) begin errors++; $display("FAIL basic_units: got seg=%h an=%b want c0", bus.seg, bus.an); end
    wait_an(2'b01, ok);
    checks++;
    if (!ok || bus.seg !== 8'hFF) begin errors++; $display("FAIL basic_tens_blank: got seg=%h an=%b want ff", bus.seg, bus.an); end
  endtask

  task automatic test_walk;
    logic [15:0] v;
    for (int i = 0; i <= 16; i++) begin
      v = (i == 16) ? 16'hFFFF : ~(16'd1 << i);
      bus.din_n = v;
      if (i == 16) push(4'd0, 1'b1, 1'b0, 1'b0);
      else push(i[3:0], 1'b0, 1'b1, 1'b0);
      for (int c = 0; c < 20; c++) begin
        step(1);
        if (sb.size() > 0 && sb[0].due == 32'(cyc)) begin
          e = sb.pop_front();
          checks++;
          if ({bus.idx, bus.gs_n, bus.eo_n, bus.held} !== {e.idx, e.gs_n, e.eo_n, e.held}) begin
            errors++;
            $display("FAIL walk_%0d: got idx=%0d gs_n=%b eo_n=%b, want %0d %b %b", i, bus.idx, bus.gs_n, bus.eo_n, e.idx, e.gs_n, e.eo_n);
          end
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL walk_drain: %0d entries left, want 0", sb.size()); sb.delete(); end
    wait_an(2'b10, ok);
    checks++;
    if (!ok || bus.seg !== 8'hBF) begin errors++; $display("FAIL walk_dash_units: got seg=%h want bf", bus.seg); end
    wait_an(2'b01, ok);
    checks++;
    if (!ok || bus.seg !== 8'hBF) begin errors++; $display("FAIL walk_dash_tens: got seg=%h want bf", bus.seg); end
  endtask

  task automatic test_multi;
    int n;
    bus.din_n = 16'h7FFE;
    push(4'd15, 1'b0, 1'b1, 1'b0);
    step(3);
    e = sb.pop_front();
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n} !== {e.idx, e.gs_n, e.eo_n}) begin
      errors++;
      $display("FAIL multi_enc: got idx=%0d gs_n=%b eo_n=%b, want %0d %b %b", bus.idx, bus.gs_n, bus.eo_n, e.idx, e.gs_n, e.eo_n);
    end
    wait_an(2'b01, ok);
    checks++;
    if (!ok || bus.seg !== 8'hF9) begin errors++; $display("FAIL multi_tens: got seg=%h want f9", bus.seg); end
    wait_an(2'b10, ok);
    n = 0;
    while (bus.an == 2'b10 && bus.seg == 8'h92 && n < 100) begin n++; step(1); end
    checks++;
    if (!ok || n != SCAN_DIV) begin errors++; $display("FAIL multi_units_dwell: got %0d cycles of 92, want %0d", n, SCAN_DIV); end
  endtask

  task automatic test_disable;
    bus.ei_n = 1'b1;
    bus.din_n = 16'h0000;
    push(4'd0, 1'b1, 1'b1, 1'b0);
    step(3);
    e = sb.pop_front();
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n} !== {e.idx, e.gs_n, e.eo_n}) begin
      errors++;
      $display("FAIL disable: got idx=%0d gs_n=%b eo_n=%b, want %0d %b %b", bus.idx, bus.gs_n, bus.eo_n, e.idx, e.gs_n, e.eo_n);
    end
    bus.ei_n = 1'b0;
    bus.din_n = 16'hFFFF;
    push(4'd0, 1'b1, 1'b0, 1'b0);
    step(3);
    e = sb.pop_front();
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n} !== {e.idx, e.gs_n, e.eo_n}) begin
      errors++;
      $display("FAIL enable_idle: got idx=%0d gs_n=%b eo_n=%b, want %0d %b %b", bus.idx, bus.gs_n, bus.eo_n, e.idx, e.gs_n, e.eo_n);
    end
  endtask

  task automatic test_latch;
    bus.latch_mode = 1'b1;
    step(2);
    bus.din_n = 16'hFFDF;
    push(4'd5, 1'b0, 1'b1, 1'b1);
    step(3);
    e = sb.pop_front();
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n, bus.held} !== {e.idx, e.gs_n, e.eo_n, e.held}) begin
      errors++;
      $display("FAIL latch_capture: got idx=%0d gs_n=%b held=%b, want %0d %b %b", bus.idx, bus.gs_n, bus.held, e.idx, e.gs_n, e.held);
    end
    step(1);
    bus.din_n = 16'hFDFF;
    step(10);
    checks++;
    if ({bus.idx, bus.held} !== {4'd5, 1'b1}) begin
      errors++;
      $display("FAIL latch_frozen: got idx=%0d held=%b, want 5 1", bus.idx, bus.held);
    end
    wait_an(2'b10, ok);
    checks++;
    if (!ok || bus.seg !== 8'h12) begin errors++; $display("FAIL latch_dp: got seg=%h want 12", bus.seg); end
    bus.clear = 1'b1;
    step(1);
    bus.clear = 1'b0;
    checks++;
    if ({bus.idx, bus.held} !== {4'd9, 1'b0}) begin
      errors++;
      $display("FAIL latch_clear: got idx=%0d held=%b, want 9 0", bus.idx, bus.held);
    end
    step(1);
    checks++;
    if ({bus.idx, bus.held} !== {4'd9, 1'b1}) begin
      errors++;
      $display("FAIL latch_recapture: got idx=%0d held=%b, want 9 1", bus.idx, bus.held);
    end
    bus.latch_mode = 1'b0;
    step(1);
    checks++;
    if (bus.held !== 1'b0) begin errors++; $display("FAIL latch_release: got held=%b want 0", bus.held); end
  endtask

  task automatic test_async_reset;
    bus.latch_mode = 1'b1;
    step(2);
    checks++;
    if (bus.held !== 1'b1) begin errors++; $display("FAIL areset_pre_held: got held=%b want 1", bus.held); end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.idx, bus.gs_n, bus.eo_n, bus.held, bus.seg, bus.an} !== {4'd0, 1'b1, 1'b1, 1'b0, 8'hFF, 2'b11}) begin
      errors++;
      $display("FAIL areset_outputs: got idx=%0d gs_n=%b eo_n=%b held=%b seg=%h an=%b, want 0 1 1 0 ff 11", bus.idx, bus.gs_n, bus.eo_n, bus.held, bus.seg, bus.an);
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.latch_mode = 1'b0;
    bus.din_n = 16'hFFFF;
    step(1);
    checks++;
    if (bus.an !== 2'b10 || bus.seg !== 8'hBF) begin
      errors++;
      $display("FAIL areset_scan_restart: got an=%b seg=%h, want 10 bf", bus.an, bus.seg);
    end
  endtask

  initial begin
    bus.din_n = 16'hFFFF;
    bus.ei_n = 1'b1;
    bus.latch_mode = 1'b0;
    bus.clear = 1'b0;
    test_reset();
    test_basic();
    test_walk();
    test_multi();
    test_disable();
    test_latch();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
